dot_product_arbiter: RTL
========================

// Module: dot_product_arbiter
// PURPOSE
//   Shares one fast_vector_dot_product pipeline among num_requesters clients.
//   Round-robin grant; at most one issue per cycle. Each issue is tagged with
//   {valid, requester id} through external_pipeline, so routing is latency-agnostic.
//   Sits between the RANSAC model-test lanes and the dot-product datapath.
//   Supports drain-to-idle (flush) and post-reset pipeline blanking.
// PARAMETERS
//   num_requesters    4   number of client ports, >= 2
//   pipeline_latency  12  clock cycles of the dot-product instance, in-to-out;
//                         must match the instance; sets the blanking window
//   id_bits           $clog2(num_requesters)  requester tag width (derived)
// PORTS
//   clock        in   1        rising-edge clock
//   reset_n      in   1        asynchronous active-low reset
//   req_valid    in   [N]      client i has a request
//   req_ready    out  [N]      client i accepted this cycle (one-hot or zero)
//   req_lhs      in   [N] ransac_fixed::vector3f_t  left operand per client
//   req_rhs      in   [N] ransac_fixed::vector3f_t  right operand per client
//   req_off      in   [N] ransac_fixed::fixed_t     FMA offset per client
//   flush        in   1        stop granting, drain in-flight work
//   res_valid    out  1        result on res_value is valid (1-cycle pulse)
//   res_id       out  id_bits  requester that owns res_value
//   res_value    out  ransac_fixed::fixed_t  dot product result
//   in_flight    out  $clog2(pipeline_latency+2)  issued, not yet returned
//   idle         out  1        state == IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0): state=BLANK, blank counter=pipeline_latency+1,
//   rr pointer=0, issue register valid=0, in_flight=0, req_ready=0,
//   res_valid=0, res_id=0, res_value=0, idle=0.
//   States:
//   - BLANK: no grants; returned tags ignored (datapath has no reset, stale
//     tags are garbage). Counter decrements each cycle; at 0 -> RUN.
//   - RUN: grant = first i with req_valid[i], searching from rr pointer upward
//     with wrap. req_ready[i] is combinational, asserted only for the winner.
//     On grant: issue register <= {valid=1, id=i, lhs, rhs, off}; rr pointer
//     <= (i+1) mod N. No winner: issue register valid <= 0, pointer holds.
//     flush=1 -> DRAIN; no grant in the cycle flush is sampled high.
//   - DRAIN: no grants. When in_flight==0 and issue register empty -> IDLE.
//   - IDLE: no grants; idle=1. flush=0 -> RUN.
//   Issue register drives the datapath every cycle (lhs, rhs, off, tag).
//   Latency: accept at edge t -> res_valid at edge t+1+pipeline_latency;
//   registered output stage adds none beyond that (res_* driven from tag out).
//   Return: when tag.valid and state != BLANK: res_valid=1, res_id=tag.id,
//   res_value=dot_product; else res_valid=0, res_value holds.
//   in_flight: +1 on grant, -1 on valid return, both same cycle -> unchanged.
//   Never exceeds pipeline_latency+1; overflow is unreachable by construction.
//   No result backpressure: clients must accept res_valid pulses matching id.
//   Offset semantics: res_value = lhs.x*rhs.x + lhs.y*rhs.y + lhs.z*rhs.z + off,
//   fixed-point, rounding/saturation exactly as the FMA datapath.
//   Reset mid-operation: all in-flight work discarded; re-enter BLANK.
//   flush asserted in BLANK: honoured on entry to RUN (goes straight to DRAIN).
// TESTING
//   1. Reset, hold all req_valid=0 for pipeline_latency+1 cycles -> no
//      req_ready, res_valid stays 0, then state RUN, in_flight=0.
//   2. Client 2 only, lhs=(1,2,3) rhs=(4,5,6) off=0.5 -> req_ready[2] once,
//      res_valid with res_id=2, res_value=32.5 exactly pipeline_latency+1 later.
//   3. All 4 clients valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3;
//      results return in the same id order, one per cycle, in_flight peaks
//      at min(8, pipeline_latency+1).
//   4. Stream 5 requests, assert flush -> no further req_ready, idle rises the
//      cycle after the 5th result; deassert flush -> grants resume at rr pointer.
//   5. Clients 1 and 3 valid, pointer at 2 -> client 3 first, then 1 (wrap).
//   6. Reset_n pulsed low with 6 in flight -> no res_valid for any of them,
//      in_flight=0, BLANK window replayed before next grant.

Source files
------------

// File: rtl/dot_product_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_arbiter (with package ransac_fixed)
// Description : Round-robin arbiter sharing one pipelined fixed-point
//               dot-product-plus-offset datapath among several clients.
//               Results are routed back by a {valid, id} tag that travels
//               alongside the data, so routing does not depend on latency.
// Revision    : 1.0 - initial release
// ============================================================================

package ransac_fixed;
    localparam int FRAC_BITS = 16;
    typedef logic signed [31:0] fixed_t;
    typedef struct packed {
        fixed_t x;
        fixed_t y;
        fixed_t z;
    } vector3f_t;
endpackage

module dot_product_arbiter #(
    parameter  int NUM_REQUESTERS   = 4,
    parameter  int PIPELINE_LATENCY = 12,
    localparam int ID_BITS          = $clog2(NUM_REQUESTERS),
    localparam int IF_BITS          = $clog2(PIPELINE_LATENCY + 2)
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic [NUM_REQUESTERS-1:0]                     req_valid,
    output logic [NUM_REQUESTERS-1:0]                     req_ready,
    input  ransac_fixed::vector3f_t [NUM_REQUESTERS-1:0]  req_lhs,
    input  ransac_fixed::vector3f_t [NUM_REQUESTERS-1:0]  req_rhs,
    input  ransac_fixed::fixed_t    [NUM_REQUESTERS-1:0]  req_off,
    input  logic                                          flush,
    output logic                                          res_valid,
    output logic [ID_BITS-1:0]                            res_id,
    output ransac_fixed::fixed_t                          res_value,
    output logic [IF_BITS-1:0]                            in_flight,
    output logic                                          idle
);
    import ransac_fixed::*;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_IDLE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
        vector3f_t          lhs;
        vector3f_t          rhs;
        fixed_t             off;
    } issue_t;

    typedef struct packed {
        logic               valid;
        logic [ID_BITS-1:0] id;
        fixed_t             value;
    } tag_t;

    localparam logic signed [65:0] SAT_MAX = 66'sd2147483647;
    localparam logic signed [65:0] SAT_MIN = -66'sd2147483648;

    // Products at full precision, truncate fraction, add offset, saturate
    function automatic fixed_t fma3(input vector3f_t a, input vector3f_t b, input fixed_t off);
        logic signed [65:0] acc;
        acc = 66'(a.x) * 66'(b.x) + 66'(a.y) * 66'(b.y) + 66'(a.z) * 66'(b.z);
        acc = (acc >>> FRAC_BITS) + 66'(off);
        if (acc > SAT_MAX) begin
            fma3 = 32'sh7fffffff;
        end else if (acc < SAT_MIN) begin
            fma3 = -32'sh80000000;
        end else begin
            fma3 = acc[31:0];
        end
    endfunction

    state_t              state_q, state_d;
    logic [IF_BITS-1:0]  blank_cnt_q, blank_cnt_d;
    logic [ID_BITS-1:0]  rr_q, rr_d;
    issue_t              issue_q, issue_d;
    logic [IF_BITS-1:0]  in_flight_q, in_flight_d;
    logic                res_valid_q, res_valid_d;
    logic [ID_BITS-1:0]  res_id_q, res_id_d;
    fixed_t              res_value_q, res_value_d;
    tag_t                pipe_q [PIPELINE_LATENCY];
    tag_t                pipe_d [PIPELINE_LATENCY];

    logic                win_found;
    logic [ID_BITS-1:0]  win_idx;
    int                  idx;
    logic                grant;
    logic                ret;
    tag_t                tag_out;

    assign tag_out = pipe_q[PIPELINE_LATENCY-1];
    // Stale tags from before reset are meaningless while blanking
    assign ret     = tag_out.valid && (state_q != ST_BLANK);

    // Round-robin search: first requester at or above the pointer, with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            idx = (int'(rr_q) + k) % NUM_REQUESTERS;
            if (!win_found && req_valid[ID_BITS'(idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_BITS'(idx);
            end
        end
    end

    // Control FSM: blanking, granting, draining and idling
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        grant       = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (blank_cnt_q == '0) begin
                    state_d = flush ? ST_DRAIN : ST_RUN;
                end else begin
                    blank_cnt_d = blank_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    grant = win_found;
                end
            end
            ST_DRAIN: begin
                if (in_flight_q == '0 && !issue_q.valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!flush) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Issue register, pointer advance, occupancy and result capture
    always_comb begin
        req_ready      = '0;
        issue_d        = issue_q;
        issue_d.valid  = 1'b0;
        rr_d           = rr_q;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
            issue_d.valid      = 1'b1;
            issue_d.id         = win_idx;
            issue_d.lhs        = req_lhs[win_idx];
            issue_d.rhs        = req_rhs[win_idx];
            issue_d.off        = req_off[win_idx];
            rr_d = (win_idx == ID_BITS'(NUM_REQUESTERS - 1)) ? '0 : win_idx + 1'b1;
        end
        case ({grant, ret})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
        res_valid_d = ret;
        res_id_d    = ret ? tag_out.id    : res_id_q;
        res_value_d = ret ? tag_out.value : res_value_q;
    end

    // Datapath stages: compute from the issue register, then delay with the tag
    always_comb begin
        pipe_d[0].valid = issue_q.valid;
        pipe_d[0].id    = issue_q.id;
        pipe_d[0].value = fma3(issue_q.lhs, issue_q.rhs, issue_q.off);
        for (int i = 1; i < PIPELINE_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Datapath has no reset; the blanking window hides its power-up contents
    always_ff @(posedge clock) begin
        pipe_q <= pipe_d;
    end

    // Control and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BLANK;
            blank_cnt_q <= IF_BITS'(PIPELINE_LATENCY + 1);
            rr_q        <= '0;
            issue_q     <= '0;
            in_flight_q <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_value_q <= '0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            rr_q        <= rr_d;
            issue_q     <= issue_d;
            in_flight_q <= in_flight_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_value_q <= res_value_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_value = res_value_q;
    assign in_flight = in_flight_q;
    assign idle      = (state_q == ST_IDLE);

endmodule
`default_nettype wire
